// File: rtl/vga_sink_monitor.sv
// VGA sink monitor: recovers line/frame timing from hs/vs on the pixel strobe,
// checks it against the expected mode, and reports a per-frame active-pixel checksum.
module vga_sink_monitor #(
   parameter int unsigned H_TOTAL  = 800,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BACK   = 48,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned V_TOTAL  = 525,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BACK   = 33,
   parameter int unsigned V_ACTIVE = 480,
   parameter logic        SYNC_POL = 1'b0
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic        PIX_EN,
   input  logic        hs,
   input  logic        vs,
   input  logic [3:0]  r,
   input  logic [3:0]  g,
   input  logic [3:0]  b,
   output logic        FRAME_DONE,
   output logic [11:0] H_MEAS,
   output logic [10:0] V_MEAS,
   output logic [15:0] CHECKSUM,
   output logic [15:0] FRAME_CNT,
   output logic        LOCKED,
   output logic        TIMING_ERR
);

   localparam int unsigned HW = 12;
   localparam int unsigned LW = HW + 1;
   localparam int unsigned VW = 11;
   localparam int unsigned SW = 16;

   localparam logic [HW-1:0] H_LO  = HW'(H_SYNC + H_BACK);
   localparam logic [HW-1:0] H_HI  = HW'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [VW-1:0] V_LO  = VW'(V_SYNC + V_BACK);
   localparam logic [VW-1:0] V_HI  = VW'(V_SYNC + V_BACK + V_ACTIVE);
   localparam logic [LW-1:0] H_LEN = LW'(H_TOTAL);
   localparam logic [HW-1:0] H_SW  = HW'(H_SYNC);
   localparam logic [VW-1:0] V_LEN = VW'(V_TOTAL);
   localparam logic [VW-1:0] V_SW  = VW'(V_SYNC);
   localparam logic [HW-1:0] H_MAX = '1;
   localparam logic [VW-1:0] V_MAX = '1;

   typedef enum logic [1:0] {IDLE = 2'd0, MEASURE = 2'd1, CLOSE = 2'd2} state_e;

   state_e          state_q, state_d;
   logic            hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
   logic [HW-1:0]   h_cnt_q, h_cnt_d, hsw_q, hsw_d;
   logic [VW-1:0]   v_cnt_q, v_cnt_d, vsw_q, vsw_d;
   logic [SW-1:0]   acc_q, acc_d;
   logic            bad_q, bad_d, first_q, first_d;
   logic [VW-1:0]   pend_v_q, pend_v_d;
   logic [SW-1:0]   pend_sum_q, pend_sum_d;
   logic            pend_good_q, pend_good_d;
   logic            done_q, done_d, locked_q, locked_d, err_q, err_d;
   logic [HW-1:0]   h_meas_q, h_meas_d;
   logic [VW-1:0]   v_meas_q, v_meas_d;
   logic [SW-1:0]   sum_q, sum_d, cnt_q, cnt_d;

   logic            hs_on, vs_on, hs_rise, vs_rise;
   logic [LW-1:0]   line_len;
   logic            line_bad, bad_next, active;
   logic [HW-1:0]   h_inc;
   logic [VW-1:0]   v_inc, v_close;
   logic [SW-1:0]   pix;

   assign hs_on    = (hs == SYNC_POL);
   assign vs_on    = (vs == SYNC_POL);
   assign hs_rise  = PIX_EN && hs_on && (hs_prev_q != SYNC_POL);
   assign vs_rise  = PIX_EN && vs_on && (vs_prev_q != SYNC_POL);
   assign line_len = {1'b0, h_cnt_q} + 13'd1;
   assign line_bad = (line_len != H_LEN) || (hsw_q != H_SW);
   assign bad_next = bad_q || (hs_rise && !first_q && line_bad);
   assign h_inc    = (h_cnt_q == H_MAX) ? h_cnt_q : h_cnt_q + 12'd1;
   assign v_inc    = (v_cnt_q == V_MAX) ? v_cnt_q : v_cnt_q + 11'd1;
   // a line closing on the same sample as the frame still counts toward that frame
   assign v_close  = hs_rise ? v_inc : v_cnt_q;
   assign pix      = SW'({r, g, b});

   // next-state, counters and status
   always_comb begin
      state_d     = state_q;
      hs_prev_d   = hs_prev_q;
      vs_prev_d   = vs_prev_q;
      h_cnt_d     = h_cnt_q;
      v_cnt_d     = v_cnt_q;
      hsw_d       = hsw_q;
      vsw_d       = vsw_q;
      acc_d       = acc_q;
      bad_d       = bad_q;
      first_d     = first_q;
      pend_v_d    = pend_v_q;
      pend_sum_d  = pend_sum_q;
      pend_good_d = pend_good_q;
      done_d      = 1'b0;
      h_meas_d    = h_meas_q;
      v_meas_d    = v_meas_q;
      sum_d       = sum_q;
      cnt_d       = cnt_q;
      locked_d    = locked_q;
      err_d       = err_q;

      if (PIX_EN) begin
         hs_prev_d = hs;
         vs_prev_d = vs;
         h_cnt_d   = hs_rise ? '0 : h_inc;
         if (vs_rise)      v_cnt_d = '0;
         else if (hs_rise) v_cnt_d = v_inc;
         if (hs_rise)                      hsw_d = HW'(1);
         else if (hs_on && hsw_q != H_MAX) hsw_d = hsw_q + 12'd1;
         // the vs pulse of a new frame starts counting at its own assert edge
         if (vs_rise)                                vsw_d = hs_rise ? VW'(1) : '0;
         else if (hs_rise && vs_on && vsw_q != V_MAX) vsw_d = vsw_q + 11'd1;
         if (hs_rise) h_meas_d = line_len[HW-1:0];
      end

      active = PIX_EN && (h_cnt_d >= H_LO) && (h_cnt_d < H_HI) &&
               (v_cnt_d >= V_LO) && (v_cnt_d < V_HI);

      case (state_q)
         IDLE: begin
            if (vs_rise) begin
               state_d = MEASURE;
               acc_d   = '0;
               bad_d   = 1'b0;
               first_d = 1'b1;
            end
         end
         MEASURE: begin
            if (hs_rise) first_d = 1'b0;
            if (vs_rise) begin
               state_d     = CLOSE;
               pend_v_d    = v_close;
               pend_sum_d  = acc_q;
               pend_good_d = !bad_next && (v_close == V_LEN) && (vsw_q == V_SW);
               acc_d       = '0;
               bad_d       = 1'b0;
            end else begin
               bad_d = bad_next;
               if (active) acc_d = acc_q + pix;
            end
         end
         CLOSE: begin
            state_d  = MEASURE;
            done_d   = 1'b1;
            v_meas_d = pend_v_q;
            sum_d    = pend_sum_q;
            cnt_d    = cnt_q + 16'd1;
            locked_d = pend_good_q;
            err_d    = err_q || !pend_good_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q     <= IDLE;
         hs_prev_q   <= 1'b0;
         vs_prev_q   <= 1'b0;
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         hsw_q       <= '0;
         vsw_q       <= '0;
         acc_q       <= '0;
         bad_q       <= 1'b0;
         first_q     <= 1'b0;
         pend_v_q    <= '0;
         pend_sum_q  <= '0;
         pend_good_q <= 1'b0;
         done_q      <= 1'b0;
         h_meas_q    <= '0;
         v_meas_q    <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         hs_prev_q   <= hs_prev_d;
         vs_prev_q   <= vs_prev_d;
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         hsw_q       <= hsw_d;
         vsw_q       <= vsw_d;
         acc_q       <= acc_d;
         bad_q       <= bad_d;
         first_q     <= first_d;
         pend_v_q    <= pend_v_d;
         pend_sum_q  <= pend_sum_d;
         pend_good_q <= pend_good_d;
         done_q      <= done_d;
         h_meas_q    <= h_meas_d;
         v_meas_q    <= v_meas_d;
         sum_q       <= sum_d;
         cnt_q       <= cnt_d;
         locked_q    <= locked_d;
         err_q       <= err_d;
      end
   end

   assign FRAME_DONE = done_q;
   assign H_MEAS     = h_meas_q;
   assign V_MEAS     = v_meas_q;
   assign CHECKSUM   = sum_q;
   assign FRAME_CNT  = cnt_q;
   assign LOCKED     = locked_q;
   assign TIMING_ERR = err_q;

endmodule

// File: tb/tb_vga_sink_monitor.sv
// Directed bench for vga_sink_monitor on a reduced 20x12 timing so whole frames stay short;
// active window is h 5..16, v 4..9 (72 pixels per frame).
module tb_vga_sink_monitor;

   localparam int unsigned HT  = 20;
   localparam int unsigned HSW = 3;
   localparam int unsigned HBP = 2;
   localparam int unsigned HAC = 12;
   localparam int unsigned VT  = 12;
   localparam int unsigned VSW = 2;
   localparam int unsigned VBP = 2;
   localparam int unsigned VAC = 6;

   logic        CLK, RSTN, PIX_EN, hs, vs;
   logic [3:0]  r, g, b;
   logic        FRAME_DONE, LOCKED, TIMING_ERR;
   logic [11:0] H_MEAS;
   logic [10:0] V_MEAS;
   logic [15:0] CHECKSUM, FRAME_CNT;

   typedef struct packed {
      logic [11:0] h;
      logic [10:0] v;
      logic [15:0] sum;
      logic [15:0] cnt;
      logic        lk;
      logic        te;
   } snap_t;

   snap_t snaps[$];
   int    checks   = 0;
   int    failures = 0;

   vga_sink_monitor #(
      .H_TOTAL(HT), .H_SYNC(HSW), .H_BACK(HBP), .H_ACTIVE(HAC),
      .V_TOTAL(VT), .V_SYNC(VSW), .V_BACK(VBP), .V_ACTIVE(VAC), .SYNC_POL(1'b0)
   ) dut (
      .CLK(CLK), .RSTN(RSTN), .PIX_EN(PIX_EN), .hs(hs), .vs(vs),
      .r(r), .g(g), .b(b),
      .FRAME_DONE(FRAME_DONE), .H_MEAS(H_MEAS), .V_MEAS(V_MEAS),
      .CHECKSUM(CHECKSUM), .FRAME_CNT(FRAME_CNT), .LOCKED(LOCKED), .TIMING_ERR(TIMING_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // every sampled FRAME_DONE cycle records the published frame results
   always @(negedge CLK)
      if (FRAME_DONE === 1'b1)
         snaps.push_back(snap_t'({H_MEAS, V_MEAS, CHECKSUM, FRAME_CNT, LOCKED, TIMING_ERR}));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_done"}, 32'(FRAME_DONE), 32'd0);
      check({tag, "_h"},    32'(H_MEAS),     32'd0);
      check({tag, "_v"},    32'(V_MEAS),     32'd0);
      check({tag, "_sum"},  32'(CHECKSUM),   32'd0);
      check({tag, "_cnt"},  32'(FRAME_CNT),  32'd0);
      check({tag, "_lk"},   32'(LOCKED),     32'd0);
      check({tag, "_te"},   32'(TIMING_ERR), 32'd0);
   endtask

   // one pixel: PIX_EN high across exactly one rising edge, then three idle clocks
   task automatic pixel(input logic h, input logic v, input logic [11:0] c);
      hs = h;
      vs = v;
      {r, g, b} = c;
      PIX_EN = 1'b1;
      @(negedge CLK);
      PIX_EN = 1'b0;
      repeat (3) @(negedge CLK);
   endtask

   task automatic frame(input int hs_w, input int vs_w, input int bad_line, input int bad_len,
                        input bit hs_off, input int mode, input int rst_line);
      for (int l = 0; l < int'(VT); l++) begin
         int len;
         len = (l == bad_line) ? bad_len : int'(HT);
         if (l == rst_line) begin
            RSTN = 1'b0;
            #1;
            check_zero("rst_mid");
            repeat (3) @(negedge CLK);
            RSTN = 1'b1;
         end
         for (int p = 0; p < len; p++) begin
            logic [11:0] c;
            logic        hv;
            case (mode)
               0:       c = 12'h000;
               1:       c = 12'h001;
               2:       c = 12'hF00;
               3:       c = 12'(l * 32 + p);
               default: c = 12'hFFF;
            endcase
            if (hs_off) hv = (l == 0 && p == 0) ? 1'b0 : 1'b1;
            else        hv = (p < hs_w) ? 1'b0 : 1'b1;
            pixel(hv, (l < vs_w) ? 1'b0 : 1'b1, c);
         end
      end
   endtask

   task automatic tail(input bit hs_off);
      for (int p = 0; p < 5; p++)
         pixel((hs_off || p >= int'(HSW)) ? 1'b1 : 1'b0, 1'b0, 12'h000);
   endtask

   task automatic expect_close(input string tag, input logic [11:0] h, input logic [10:0] v,
                               input logic [15:0] sum, input logic [15:0] cnt,
                               input logic lk, input logic te);
      snap_t s;
      check({tag, "_present"}, 32'(snaps.size() > 0), 32'd1);
      if (snaps.size() > 0) begin
         s = snaps.pop_front();
         check({tag, "_h"},   32'(s.h),   32'(h));
         check({tag, "_v"},   32'(s.v),   32'(v));
         check({tag, "_sum"}, 32'(s.sum), 32'(sum));
         check({tag, "_cnt"}, 32'(s.cnt), 32'(cnt));
         check({tag, "_lk"},  32'(s.lk),  32'(lk));
         check({tag, "_te"},  32'(s.te),  32'(te));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      RSTN = 1'b1; PIX_EN = 1'b0; hs = 1'b1; vs = 1'b1; {r, g, b} = 12'h000;
      @(negedge CLK);
      RSTN = 1'b0;
      repeat (3) @(negedge CLK);
      check_zero("rst");
      RSTN = 1'b1;
      repeat (8) pixel(1'b1, 1'b1, 12'h000);

      // nominal frames with the checksum patterns
      frame(HSW, VSW, -1, HT, 1'b0, 1, -1);
      frame(HSW, VSW, -1, HT, 1'b0, 2, -1);
      expect_close("A", 12'd20, 11'd12, 16'h0048, 16'd1, 1'b1, 1'b0);
      frame(HSW, VSW, -1, HT, 1'b0, 3, -1);
      expect_close("B", 12'd20, 11'd12, 16'h3800, 16'd2, 1'b1, 1'b0);
      frame(HSW, VSW, -1, HT, 1'b0, 4, -1);
      expect_close("C", 12'd20, 11'd12, 16'h3D74, 16'd3, 1'b1, 1'b0);

      // one long line, then recovery
      frame(HSW, VSW, 5, HT + 1, 1'b0, 0, -1);
      expect_close("D", 12'd20, 11'd12, 16'h7FB8, 16'd4, 1'b1, 1'b0);
      frame(HSW, VSW, -1, HT, 1'b0, 0, -1);
      expect_close("E_longline", 12'd20, 11'd12, 16'h0000, 16'd5, 1'b0, 1'b1);

      // short hs pulse, then a 3-line vs pulse
      frame(HSW - 1, VSW, -1, HT, 1'b0, 0, -1);
      expect_close("F", 12'd20, 11'd12, 16'h0000, 16'd6, 1'b1, 1'b1);
      frame(HSW, VSW + 1, -1, HT, 1'b0, 0, -1);
      expect_close("G_hsw", 12'd20, 11'd12, 16'h0000, 16'd7, 1'b0, 1'b1);
      frame(HSW, VSW, -1, HT, 1'b0, 0, -1);
      expect_close("H_vsw", 12'd20, 11'd12, 16'h0000, 16'd8, 1'b0, 1'b1);

      // hs held deasserted for a whole frame
      frame(HSW, VSW, -1, HT, 1'b1, 0, -1);
      expect_close("I", 12'd20, 11'd12, 16'h0000, 16'd9, 1'b1, 1'b1);
      tail(1'b1);
      expect_close("J_nohs", 12'd20, 11'd0, 16'h0000, 16'd10, 1'b0, 1'b1);
      check("pre_rst_extra", 32'(snaps.size()), 32'd0);

      // reset mid-frame, then the first frame after it is only armed
      frame(HSW, VSW, -1, HT, 1'b0, 0, 5);
      frame(HSW, VSW, -1, HT, 1'b0, 0, -1);
      check("post_rst_no_done", 32'(snaps.size()), 32'd0);
      frame(HSW, VSW, -1, HT, 1'b0, 1, -1);
      expect_close("M", 12'd20, 11'd12, 16'h0000, 16'd1, 1'b1, 1'b0);
      tail(1'b0);
      expect_close("N", 12'd20, 11'd12, 16'h0048, 16'd2, 1'b1, 1'b0);

      repeat (8) @(negedge CLK);
      check("end_extra", 32'(snaps.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
